// File: rtl/memory_sequence_ctrl.sv
// Memory-sequence game controller: walks the pattern ROM round by
// round and checks each button press against the stored sequence.
module memory_sequence_ctrl #(
  parameter int LAST_ROUND     = 15,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] botoes,
  input  logic [3:0] rom_data,
  output logic [3:0] rom_address,
  output logic       rom_enable,
  output logic [3:0] rodada,
  output logic [3:0] jogada,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST = 4'(LAST_ROUND);

  localparam logic [3:0] INICIAL       = 4'd0;
  localparam logic [3:0] PREPARA       = 4'd1;
  localparam logic [3:0] LE_ROM        = 4'd2;
  localparam logic [3:0] ESPERA_DADO   = 4'd3;
  localparam logic [3:0] ESPERA_JOGADA = 4'd4;
  localparam logic [3:0] REGISTRA      = 4'd5;
  localparam logic [3:0] COMPARA       = 4'd6;
  localparam logic [3:0] PROX_JOGADA   = 4'd7;
  localparam logic [3:0] PROX_RODADA   = 4'd8;
  localparam logic [3:0] FIM_ACERTO    = 4'd10;
  localparam logic [3:0] FIM_ERRO      = 4'd11;
  localparam logic [3:0] FIM_TIMEOUT   = 4'd12;

  logic [3:0]    state_q, state_d;
  logic [3:0]    rodada_q, rodada_d;
  logic [3:0]    jogada_q, jogada_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    btn_q, btn_d;
  logic [3:0]    exp_q, exp_d;
  logic [3:0]    prev_q;
  logic          pronto_q, pronto_d;
  logic          acertou_q, acertou_d;
  logic          errou_q, errou_d;
  logic          timeout_q, timeout_d;
  logic          press;

  // A press is a rising edge out of the all-released condition.
  assign press = (botoes != 4'd0) && (prev_q == 4'd0);

  always_comb begin
    state_d   = state_q;
    rodada_d  = rodada_q;
    jogada_d  = jogada_q;
    tmo_d     = tmo_q;
    btn_d     = btn_q;
    exp_d     = exp_q;
    pronto_d  = pronto_q;
    acertou_d = acertou_q;
    errou_d   = errou_q;
    timeout_d = timeout_q;
    case (state_q)
      INICIAL: if (iniciar) state_d = PREPARA;
      PREPARA: begin
        rodada_d  = 4'd0;
        jogada_d  = 4'd0;
        tmo_d     = '0;
        btn_d     = 4'd0;
        pronto_d  = 1'b0;
        acertou_d = 1'b0;
        errou_d   = 1'b0;
        timeout_d = 1'b0;
        state_d   = LE_ROM;
      end
      LE_ROM: state_d = ESPERA_DADO;
      ESPERA_DADO: begin
        exp_d   = rom_data;
        state_d = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        if (press) begin
          state_d = REGISTRA;
        end else if (tmo_q == T_LAST) begin
          timeout_d = 1'b1;
          pronto_d  = 1'b1;
          state_d   = FIM_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      REGISTRA: begin
        btn_d   = botoes;
        tmo_d   = '0;
        state_d = COMPARA;
      end
      COMPARA: begin
        if (btn_q != exp_q) begin
          errou_d  = 1'b1;
          pronto_d = 1'b1;
          state_d  = FIM_ERRO;
        end else if (jogada_q == rodada_q) begin
          state_d = PROX_RODADA;
        end else begin
          state_d = PROX_JOGADA;
        end
      end
      PROX_JOGADA: begin
        jogada_d = jogada_q + 4'd1;
        state_d  = LE_ROM;
      end
      PROX_RODADA: begin
        if (rodada_q == LAST) begin
          acertou_d = 1'b1;
          pronto_d  = 1'b1;
          state_d   = FIM_ACERTO;
        end else begin
          rodada_d = rodada_q + 4'd1;
          jogada_d = 4'd0;
          state_d  = LE_ROM;
        end
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
        if (iniciar) state_d = PREPARA;
      default: state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= INICIAL;
      rodada_q  <= 4'd0;
      jogada_q  <= 4'd0;
      tmo_q     <= '0;
      btn_q     <= 4'd0;
      exp_q     <= 4'd0;
      prev_q    <= 4'd0;
      pronto_q  <= 1'b0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rodada_q  <= rodada_d;
      jogada_q  <= jogada_d;
      tmo_q     <= tmo_d;
      btn_q     <= btn_d;
      exp_q     <= exp_d;
      prev_q    <= botoes;
      pronto_q  <= pronto_d;
      acertou_q <= acertou_d;
      errou_q   <= errou_d;
      timeout_q <= timeout_d;
    end
  end

  assign rom_enable  = (state_q == LE_ROM);
  assign rom_address = rom_enable ? jogada_q : 4'd0;
  assign rodada      = rodada_q;
  assign jogada      = jogada_q;
  assign pronto      = pronto_q;
  assign acertou     = acertou_q;
  assign errou       = errou_q;
  assign timeout     = timeout_q;
  assign db_estado   = state_q;

endmodule
